mode_request_gen: RTL and testbench

MODE_REQUEST_GEN -- requirements
Module: mode_request_gen

---
 rtl/mode_request_gen.sv | 136 +++++++++++++
 tb/tb_mode_request_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mode_request_gen.sv
// Pushbutton front end for the mode controller: synchronizes and debounces four
// buttons, then turns debounced presses into single registered mode-request pulses.
module mode_request_gen #(
    parameter int DB_COUNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [1:0] mode,
    output logic       set_edit,
    output logic       set_play,
    output logic       set_raw
);

    localparam int CNT_W = $clog2(DB_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    localparam logic [1:0] MODE_EDIT = 2'd0;
    localparam logic [1:0] MODE_PLAY = 2'd1;
    localparam logic [1:0] MODE_RAW  = 2'd2;

    localparam int BTN_EDIT  = 0;
    localparam int BTN_PLAY  = 1;
    localparam int BTN_RAW   = 2;
    localparam int BTN_CYCLE = 3;

    logic [3:0]            sync1_q;
    logic [3:0]            sync2_q;
    logic [3:0]            db_q;
    logic [3:0]            db_d;
    logic [3:0]            db_prev_q;
    logic [3:0][CNT_W-1:0] cnt_q;
    logic [3:0][CNT_W-1:0] cnt_d;

    logic [3:0] press;
    logic       req_vld;
    logic [1:0] req_mode;
    logic       set_edit_q;
    logic       set_edit_d;
    logic       set_play_q;
    logic       set_play_d;
    logic       set_raw_q;
    logic       set_raw_d;

    // Mode reached by the cycle button; undefined mode falls back to edit.
    function automatic logic [1:0] cycle_target(input logic [1:0] cur);
        case (cur)
            MODE_EDIT: cycle_target = MODE_PLAY;
            MODE_PLAY: cycle_target = MODE_RAW;
            default:   cycle_target = MODE_EDIT;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // A change is accepted only after DB_COUNT consecutive differing cycles;
    // any cycle of agreement restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press = db_q & ~db_prev_q;

    // Only the highest-priority press is resolved; suppressing it does not
    // hand the slot to a lower-priority press.
    always_comb begin
        req_vld  = 1'b0;
        req_mode = MODE_EDIT;
        if (press[BTN_EDIT]) begin
            req_vld  = 1'b1;
            req_mode = MODE_EDIT;
        end else if (press[BTN_PLAY]) begin
            req_vld  = 1'b1;
            req_mode = MODE_PLAY;
        end else if (press[BTN_RAW]) begin
            req_vld  = 1'b1;
            req_mode = MODE_RAW;
        end else if (press[BTN_CYCLE]) begin
            req_vld  = 1'b1;
            req_mode = cycle_target(mode);
        end
        if (req_mode == mode) begin
            req_vld = 1'b0;
        end
        set_edit_d = req_vld && (req_mode == MODE_EDIT);
        set_play_d = req_vld && (req_mode == MODE_PLAY);
        set_raw_d  = req_vld && (req_mode == MODE_RAW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_edit_q <= 1'b0;
            set_play_q <= 1'b0;
            set_raw_q  <= 1'b0;
        end else begin
            set_edit_q <= set_edit_d;
            set_play_q <= set_play_d;
            set_raw_q  <= set_raw_d;
        end
    end

    assign set_edit = set_edit_q;
    assign set_play = set_play_q;
    assign set_raw  = set_raw_q;

endmodule

// File: tb/tb_mode_request_gen.sv
// Directed bench for mode_request_gen with DB_COUNT=4; outputs are viewed as
// {set_raw, set_play, set_edit} and sampled 1 time unit after each rising edge.
module tb_mode_request_gen;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [1:0] mode;
    logic       set_edit;
    logic       set_play;
    logic       set_raw;
    logic [2:0] outs;

    int n_vec;
    int n_miss;

    localparam logic [2:0] P_NONE = 3'b000;
    localparam logic [2:0] P_EDIT = 3'b001;
    localparam logic [2:0] P_PLAY = 3'b010;
    localparam logic [2:0] P_RAW  = 3'b100;

    mode_request_gen #(.DB_COUNT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .mode     (mode),
        .set_edit (set_edit),
        .set_play (set_play),
        .set_raw  (set_raw)
    );

    assign outs = {set_raw, set_play, set_edit};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges; index k is the k-th edge after the call. Expect pv at
    // index pulse_at and silence everywhere else (pulse_at < 0: never).
    task automatic run_expect(input string tag, input int n, input int pulse_at,
                              input logic [2:0] pv);
        for (int k = 0; k < n; k++) begin
            tick();
            check_vec($sformatf("%s[%0d]", tag, k), outs, (k == pulse_at) ? pv : P_NONE);
        end
    endtask

    task automatic release_all(input string tag);
        btn = 4'b0000;
        run_expect(tag, 12, -1, P_NONE);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        btn    = 4'b0000;
        mode   = 2'd0;
        #3;
        check_vec("reset_state", outs, P_NONE);
        tick();
        tick();
        rst = 1'b0;
        run_expect("idle", 4, -1, P_NONE);

        // play held from edge 0: pulse after edge 6 only
        mode = 2'd0;
        btn  = 4'b0010;
        run_expect("play_hold", 16, 6, P_PLAY);
        release_all("play_rel");

        // 3-cycle glitch is rejected, 5-cycle press accepted
        mode = 2'd1;
        btn  = 4'b0001;
        run_expect("edit_glitch", 3, -1, P_NONE);
        btn = 4'b0000;
        run_expect("edit_glitch_rel", 8, -1, P_NONE);
        btn = 4'b0001;
        run_expect("edit_press5", 5, -1, P_NONE);
        btn = 4'b0000;
        run_expect("edit_after5", 2, 1, P_EDIT);
        release_all("edit_rel");

        // edit and raw together: edit wins, raw discarded
        mode = 2'd1;
        btn  = 4'b0101;
        run_expect("edit_raw", 16, 6, P_EDIT);
        release_all("edit_raw_rel");

        // cycle button through every mode
        for (int m = 0; m < 4; m++) begin
            logic [2:0] exp_c;
            mode = 2'(m);
            case (m)
                0:       exp_c = P_PLAY;
                1:       exp_c = P_RAW;
                default: exp_c = P_EDIT;
            endcase
            btn = 4'b1000;
            run_expect($sformatf("cycle_m%0d", m), 10, 6, exp_c);
            release_all($sformatf("cycle_m%0d_rel", m));
        end

        // raw while in raw: suppressed; raw+cycle in raw: nothing
        mode = 2'd2;
        btn  = 4'b0100;
        run_expect("raw_supp", 12, -1, P_NONE);
        release_all("raw_supp_rel");
        btn = 4'b1100;
        run_expect("raw_cycle_supp", 12, -1, P_NONE);
        release_all("raw_cycle_rel");

        // edit+play in edit: edit suppressed, play not promoted
        mode = 2'd0;
        btn  = 4'b0011;
        run_expect("edit_play_supp", 12, -1, P_NONE);
        release_all("edit_play_rel");

        // mode only matters in the resolution cycle (between edges 5 and 6)
        mode = 2'd1;
        btn  = 4'b1000;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_vec($sformatf("mode_sample[%0d]", k), outs, (k == 6) ? P_PLAY : P_NONE);
            if (k == 5) mode = 2'd0;
            if (k == 6) mode = 2'd2;
        end
        release_all("mode_sample_rel");

        // reset mid-debounce aborts; held button re-pressed after release
        mode = 2'd0;
        btn  = 4'b0010;
        run_expect("rst_db_pre", 4, -1, P_NONE);
        rst = 1'b1;
        #1;
        check_vec("rst_db_async", outs, P_NONE);
        tick();
        tick();
        rst = 1'b0;
        run_expect("rst_db_post", 20, 6, P_PLAY);
        release_all("rst_db_rel");

        // reset during an output pulse clears it immediately, no re-emission
        mode = 2'd0;
        btn  = 4'b0100;
        run_expect("rst_pulse_pre", 7, 6, P_RAW);
        rst = 1'b1;
        #1;
        check_vec("rst_pulse_abort", outs, P_NONE);
        btn = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        run_expect("rst_pulse_post", 12, -1, P_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
